if_prefetch_stage: RTL
======================

Name: if_prefetch_stage

Overview:
Parametrised instruction-fetch stage. It decouples the PC/instruction-memory side from ID using a DEPTH-entry prefetch queue. Handshakes are valid/ready on both the memory and ID sides. Branch/J/JR/interrupt/exception redirects flush the queue and drop any in-flight stale response. It replaces the single-register fetch stage feeding ID.

Parameters:
XLEN, 32, PC/address width
DEPTH, 4, prefetch queue entries; power of 2, >=2
RESET_VEC, 32'h8000_0000, PC after reset
IRQ_VEC, 32'h8000_0004, interrupt redirect target
EXC_VEC, 32'h8000_0008, exception redirect target
KEEP_MSB, 1, 1: PC increment preserves PC[XLEN-1] (supervisor bit); 0: full-width +4

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
imem_req  out  1  fetch request valid
imem_addr  out  XLEN  fetch address (current PC)
imem_ready  in  1  memory accepts request this cycle
imem_rvalid  in  1  response valid, in order, >=1 cycle after accept
imem_rdata  in  32  instruction word
sel_next  in  3  {Z,J,JR}, one-hot or zero
branch_target  in  XLEN  target when sel_next=100
jump_target  in  XLEN  target when sel_next=010
jr_target  in  XLEN  target when sel_next=001
status  in  2  {interrupt, exception}
id_valid  out  1  queue head valid
id_ready  in  1  ID consumes head
id_pc_plus4  out  XLEN  PC+4 of head instruction
id_instr  out  32  head instruction
sel_err  out  1  sticky: multi-hot sel_next seen

Behaviour:
- Reset (async): PC=RESET_VEC, queue empty, outstanding=0, discard=0, sel_err=0. imem_req=0, id_valid=0, id_pc_plus4=0, id_instr=0.
- inc(x): KEEP_MSB ? {x[XLEN-1], x[XLEN-2:0]+4} : x+4; wraps silently.
- Redirect = |sel_next | |status. Priority: sel_next non-zero over status.
  - sel 100/010/001 -> branch/jump/jr target.
  - sel 000, status 01 or 11 -> EXC_VEC (exception beats interrupt).
  - sel 000, status 10 -> IRQ_VEC.
  - Any other non-zero sel -> PC=all-ones, sel_err<=1.
- Redirect cycle: PC<=target; queue flushed (a simultaneous pop is irrelevant); imem_req forced 0.
- Redirect cycle, outstanding=1: if imem_rvalid in same cycle, response dropped and outstanding<=0, discard stays 0; else discard<=1.
- At most one outstanding request.
- imem_req = ~redirect & ~outstanding & (count < DEPTH); imem_addr = PC.
- Accept (imem_req & imem_ready): req_pc<=PC, PC<=inc(PC), outstanding<=1.
- Response (imem_rvalid & outstanding):
  - outstanding<=0.
  - discard=1: drop the word, discard<=0.
  - Otherwise push {inc(req_pc), imem_rdata}.
- imem_rvalid with outstanding=0 is ignored.
- Queue: id_valid = count!=0; pop on id_valid & id_ready. Push and pop in the same cycle are allowed, count unchanged.
- Full: no push can be lost, because requests are gated on count<DEPTH.
- Latency: accept at cycle t, rvalid at t+1 -> id_valid at t+2. Pipelined throughput: 1 instruction per 2 cycles with 1-outstanding.
- Outputs hold while id_valid & ~id_ready.

Decomposition:
- Package if_pkg: reset/IRQ/EXC vector defaults, sel_next encodings (SEL_NONE/BR/J/JR), status encodings, queue entry width XLEN+32.
- Sub-module if_fetch_fifo: synchronous DEPTH x (XLEN+32) FIFO with push, pop, flush, count, head outputs. Flush has priority over push and pop.

Test Plan:
- Reset, imem_ready=1, rvalid one cycle after each accept, id_ready=1 -> addresses 8000_0000, 8000_0004, …; ID sees pc_plus4 8000_0004 with the first word.
- id_ready=0, DEPTH=4 -> exactly 4 entries queued, imem_req then 0. Raise id_ready -> entries in order, fetch resumes at PC 8000_0010.
- Request outstanding, sel_next=100, branch_target=8000_0100, rvalid arrives 2 cycles later -> stale word dropped; next imem_addr=8000_0100; queue empty during the redirect cycle.
- status=11 with sel_next=000 -> PC=8000_0008. status=10 plus sel_next=010 (jump_target=8000_0040) -> PC=8000_0040.
- sel_next=110 -> PC=FFFF_FFFF, sel_err=1, sticky until reset.
- KEEP_MSB=1, PC=FFFF_FFFC, accept -> next PC=8000_0000. rst_n low mid-fetch -> all outputs at reset values immediately.

Source files
------------

// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch prefetch stage: vector defaults,
// redirect-select and status encodings, and the queue entry width.
package if_pkg;

    localparam logic [31:0] RESET_VEC_DEF = 32'h8000_0000;
    localparam logic [31:0] IRQ_VEC_DEF   = 32'h8000_0004;
    localparam logic [31:0] EXC_VEC_DEF   = 32'h8000_0008;

    // sel_next is {Z, J, JR}; anything other than these four is a select error.
    localparam logic [2:0] SEL_NONE = 3'b000;
    localparam logic [2:0] SEL_BR   = 3'b100;
    localparam logic [2:0] SEL_J    = 3'b010;
    localparam logic [2:0] SEL_JR   = 3'b001;

    // status is {interrupt, exception}.
    localparam logic [1:0] STAT_NONE = 2'b00;
    localparam logic [1:0] STAT_EXC  = 2'b01;
    localparam logic [1:0] STAT_IRQ  = 2'b10;

    localparam int INSTR_W = 32;

    // A queue entry carries {pc_plus4, instr}.
    function automatic int entry_w(input int xlen);
        return xlen + INSTR_W;
    endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// Synchronous prefetch queue; flush wins over push and pop, head reads as zero when empty.
module if_fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [WIDTH-1:0]           head_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [AW:0]      count_q;
    logic             not_empty, do_pop, do_push;

    assign not_empty = (count_q != '0);
    assign do_pop    = pop_i & not_empty & ~flush_i;
    assign do_push   = push_i & ~flush_i & ((count_q != (AW+1)'(DEPTH)) | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // NOTE: storage is deliberately not reset; validity lives in count_q alone.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign count_o = count_q;
    assign head_o  = not_empty ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage: one-outstanding memory fetcher feeding ID through a
// DEPTH-entry prefetch queue, with redirect flush and stale-response discard.
module if_prefetch_stage
    import if_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 4,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEF),
    parameter logic [XLEN-1:0] IRQ_VEC   = XLEN'(IRQ_VEC_DEF),
    parameter logic [XLEN-1:0] EXC_VEC   = XLEN'(EXC_VEC_DEF),
    parameter bit              KEEP_MSB  = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic [2:0]      sel_next,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] jump_target,
    input  logic [XLEN-1:0] jr_target,
    input  logic [1:0]      status,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc_plus4,
    output logic [31:0]     id_instr,
    output logic            sel_err
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = entry_w(XLEN);

    function automatic logic [XLEN-1:0] inc(input logic [XLEN-1:0] x);
        if (KEEP_MSB) return {x[XLEN-1], x[XLEN-2:0] + (XLEN-1)'(4)};
        return x + XLEN'(4);
    endfunction

    logic [XLEN-1:0] pc_q, pc_d, req_pc_q, req_pc_d, target;
    logic            out_q, out_d, disc_q, disc_d, sel_err_q, sel_err_d;
    logic            redirect, sel_bad, accept, resp, push, pop;
    logic [CW-1:0]   count;
    logic [EW-1:0]   head;

    assign redirect = (sel_next != SEL_NONE) | (status != STAT_NONE);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        target  = '1;
        sel_bad = 1'b0;
        case (sel_next)
            SEL_BR:   target = branch_target;
            SEL_J:    target = jump_target;
            SEL_JR:   target = jr_target;
            SEL_NONE: target = (status & STAT_EXC) != STAT_NONE ? EXC_VEC : IRQ_VEC;
            default:  sel_bad = 1'b1;
        endcase
    end

    // Reset gates the request combinationally so it drops the moment rst_n falls.
    assign imem_req  = rst_n & ~redirect & ~out_q & (count < CW'(DEPTH));
    assign imem_addr = pc_q;
    assign accept    = imem_req & imem_ready;
    assign resp      = imem_rvalid & out_q;
    assign push      = resp & ~disc_q;
    assign pop       = id_valid & id_ready;

    always_comb begin
        pc_d      = pc_q;
        req_pc_d  = req_pc_q;
        out_d     = out_q;
        disc_d    = disc_q;
        sel_err_d = sel_err_q | sel_bad;
        if (redirect) begin
            pc_d = target;
        end else if (accept) begin
            pc_d     = inc(pc_q);
            req_pc_d = pc_q;
            out_d    = 1'b1;
        end
        // A response landing in the redirect cycle is dropped by the flush, so no discard is armed.
        if (resp) begin
            out_d  = 1'b0;
            disc_d = 1'b0;
        end else if (redirect && out_q) begin
            disc_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_VEC;
            req_pc_q  <= '0;
            out_q     <= 1'b0;
            disc_q    <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            req_pc_q  <= req_pc_d;
            out_q     <= out_d;
            disc_q    <= disc_d;
            sel_err_q <= sel_err_d;
        end
    end

    if_fetch_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (redirect),
        .push_i  (push),
        .data_i  ({inc(req_pc_q), imem_rdata}),
        .pop_i   (pop),
        .count_o (count),
        .head_o  (head)
    );

    assign id_valid    = (count != '0);
    assign id_pc_plus4 = head[EW-1:INSTR_W];
    assign id_instr    = head[INSTR_W-1:0];
    assign sel_err     = sel_err_q;

endmodule
